// File: rtl/alu_reservation_station_if.sv
// ALU issue/return handshake: the reservation station drives the master side, the ALU the slave side.
interface alu_reservation_station_if #(
    parameter int RS_WIDTH = 2
);
    logic                cal;
    logic [31:0]         a;
    logic [31:0]         b;
    logic [3:0]          alu_op;
    logic [RS_WIDTH-1:0] to_alu_index;
    logic                alu_done;
    logic [RS_WIDTH-1:0] alu_index;
    logic [31:0]         alu_result;

    modport master (
        output cal, a, b, alu_op, to_alu_index,
        input  alu_done, alu_index, alu_result
    );

    modport slave (
        input  cal, a, b, alu_op, to_alu_index,
        output alu_done, alu_index, alu_result
    );
endinterface

// File: rtl/alu_reservation_station.sv
// Tomasulo ALU reservation station: holds renamed ops, wakes operands, dispatches one ready op per cycle.
// Define RS_AGE_SELECT_EN for oldest-ready-first selection via an age matrix; otherwise lowest index wins.
module alu_reservation_station #(
    parameter int ROB_WIDTH = 4,
    parameter int RS_WIDTH  = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear,
    input  logic                     issue_valid,
    input  logic [3:0]               issue_op,
    input  logic [31:0]              issue_vj,
    input  logic [31:0]              issue_vk,
    input  logic [ROB_WIDTH-1:0]     issue_qj,
    input  logic [ROB_WIDTH-1:0]     issue_qk,
    input  logic                     issue_qj_busy,
    input  logic                     issue_qk_busy,
    input  logic [ROB_WIDTH-1:0]     issue_dest,
    output logic                     rs_full,
    input  logic                     cdb_valid,
    input  logic [ROB_WIDTH-1:0]     cdb_rob,
    input  logic [31:0]              cdb_value,
    alu_reservation_station_if.master alu,
    output logic                     out_valid,
    output logic [ROB_WIDTH-1:0]     out_rob,
    output logic [31:0]              out_value
);
    localparam int DEPTH = 1 << RS_WIDTH;

    logic [DEPTH-1:0]     busy_q, busy_d;
    logic [DEPTH-1:0]     qj_busy_q, qj_busy_d;
    logic [DEPTH-1:0]     qk_busy_q, qk_busy_d;
    logic [3:0]           op_q [DEPTH];
    logic [3:0]           op_d [DEPTH];
    logic [31:0]          vj_q [DEPTH];
    logic [31:0]          vj_d [DEPTH];
    logic [31:0]          vk_q [DEPTH];
    logic [31:0]          vk_d [DEPTH];
    logic [ROB_WIDTH-1:0] qj_q [DEPTH];
    logic [ROB_WIDTH-1:0] qj_d [DEPTH];
    logic [ROB_WIDTH-1:0] qk_q [DEPTH];
    logic [ROB_WIDTH-1:0] qk_d [DEPTH];
    logic [ROB_WIDTH-1:0] dest_q [DEPTH];
    logic [ROB_WIDTH-1:0] dest_d [DEPTH];
    logic [ROB_WIDTH-1:0] dispatch_tag_q [DEPTH];
    logic [ROB_WIDTH-1:0] dispatch_tag_d [DEPTH];

    logic                 cal_q, cal_d;
    logic [31:0]          a_q, a_d;
    logic [31:0]          b_q, b_d;
    logic [3:0]           alu_op_q, alu_op_d;
    logic [RS_WIDTH-1:0]  index_q, index_d;

    logic                 out_valid_q, out_valid_d;
    logic [ROB_WIDTH-1:0] out_rob_q, out_rob_d;
    logic [31:0]          out_value_q, out_value_d;
    logic                 drop_q, drop_d;

    logic [DEPTH-1:0]     ready;
    logic                 sel_valid;
    logic [RS_WIDTH-1:0]  sel_idx;
    logic                 alloc_valid;
    logic [RS_WIDTH-1:0]  alloc_idx;

`ifdef RS_AGE_SELECT_EN
    // age_q[i][j] set means entry i was allocated before entry j and both still hold ops.
    logic [DEPTH-1:0]     age_q [DEPTH];
    logic [DEPTH-1:0]     age_d [DEPTH];
    logic [DEPTH-1:0]     has_older_ready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            has_older_ready[i] = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && ready[j] && age_q[j][i]) begin
                    has_older_ready[i] = 1'b1;
                end
            end
        end
    end
`endif

    always_comb begin
        ready       = busy_q & ~qj_busy_q & ~qk_busy_q;
        sel_valid   = 1'b0;
        sel_idx     = '0;
        alloc_valid = 1'b0;
        alloc_idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
`ifdef RS_AGE_SELECT_EN
            if (ready[i] && !has_older_ready[i]) begin
`else
            if (ready[i]) begin
`endif
                sel_valid = 1'b1;
                sel_idx   = RS_WIDTH'(i);
            end
            if (!busy_q[i]) begin
                alloc_valid = 1'b1;
                alloc_idx   = RS_WIDTH'(i);
            end
        end
    end

    assign rs_full = &busy_q;

    always_comb begin
        busy_d         = busy_q;
        qj_busy_d      = qj_busy_q;
        qk_busy_d      = qk_busy_q;
        op_d           = op_q;
        vj_d           = vj_q;
        vk_d           = vk_q;
        qj_d           = qj_q;
        qk_d           = qk_q;
        dest_d         = dest_q;
        dispatch_tag_d = dispatch_tag_q;
        cal_d          = cal_q;
        a_d            = a_q;
        b_d            = b_q;
        alu_op_d       = alu_op_q;
        index_d        = index_q;
`ifdef RS_AGE_SELECT_EN
        age_d          = age_q;
`endif
        if (rdy_in && clear) begin
            busy_d = '0;
            cal_d  = 1'b0;
`ifdef RS_AGE_SELECT_EN
            for (int i = 0; i < DEPTH; i++) begin
                age_d[i] = '0;
            end
`endif
        end else if (rdy_in) begin
            // Both the external CDB and our own result bus can wake operands in the same cycle.
            for (int i = 0; i < DEPTH; i++) begin
                if (busy_q[i] && qj_busy_q[i]) begin
                    if (cdb_valid && cdb_rob == qj_q[i]) begin
                        vj_d[i]      = cdb_value;
                        qj_busy_d[i] = 1'b0;
                    end else if (out_valid_q && out_rob_q == qj_q[i]) begin
                        vj_d[i]      = out_value_q;
                        qj_busy_d[i] = 1'b0;
                    end
                end
                if (busy_q[i] && qk_busy_q[i]) begin
                    if (cdb_valid && cdb_rob == qk_q[i]) begin
                        vk_d[i]      = cdb_value;
                        qk_busy_d[i] = 1'b0;
                    end else if (out_valid_q && out_rob_q == qk_q[i]) begin
                        vk_d[i]      = out_value_q;
                        qk_busy_d[i] = 1'b0;
                    end
                end
            end

            cal_d = sel_valid;
            if (sel_valid) begin
                a_d                     = vj_q[sel_idx];
                b_d                     = vk_q[sel_idx];
                alu_op_d                = op_q[sel_idx];
                index_d                 = sel_idx;
                busy_d[sel_idx]         = 1'b0;
                dispatch_tag_d[sel_idx] = dest_q[sel_idx];
`ifdef RS_AGE_SELECT_EN
                for (int j = 0; j < DEPTH; j++) begin
                    age_d[sel_idx][j] = 1'b0;
                    age_d[j][sel_idx] = 1'b0;
                end
`endif
            end

            if (issue_valid && alloc_valid) begin
                busy_d[alloc_idx]    = 1'b1;
                op_d[alloc_idx]      = issue_op;
                dest_d[alloc_idx]    = issue_dest;
                qj_d[alloc_idx]      = issue_qj;
                qk_d[alloc_idx]      = issue_qk;
                vj_d[alloc_idx]      = issue_vj;
                vk_d[alloc_idx]      = issue_vk;
                qj_busy_d[alloc_idx] = issue_qj_busy;
                qk_busy_d[alloc_idx] = issue_qk_busy;
                // A producer broadcasting in the allocation cycle would otherwise be missed forever.
                if (issue_qj_busy) begin
                    if (cdb_valid && cdb_rob == issue_qj) begin
                        vj_d[alloc_idx]      = cdb_value;
                        qj_busy_d[alloc_idx] = 1'b0;
                    end else if (out_valid_q && out_rob_q == issue_qj) begin
                        vj_d[alloc_idx]      = out_value_q;
                        qj_busy_d[alloc_idx] = 1'b0;
                    end
                end
                if (issue_qk_busy) begin
                    if (cdb_valid && cdb_rob == issue_qk) begin
                        vk_d[alloc_idx]      = cdb_value;
                        qk_busy_d[alloc_idx] = 1'b0;
                    end else if (out_valid_q && out_rob_q == issue_qk) begin
                        vk_d[alloc_idx]      = out_value_q;
                        qk_busy_d[alloc_idx] = 1'b0;
                    end
                end
`ifdef RS_AGE_SELECT_EN
                for (int j = 0; j < DEPTH; j++) begin
                    age_d[alloc_idx][j] = 1'b0;
                    age_d[j][alloc_idx] = (j != int'(alloc_idx)) && busy_d[j];
                end
`endif
            end
        end
    end

    // The result latch runs even while paused; an op already in the ALU when a flush hits is discarded.
    always_comb begin
        out_valid_d = out_valid_q;
        out_rob_d   = out_rob_q;
        out_value_d = out_value_q;
        drop_d      = 1'b0;
        if (rdy_in && clear) begin
            out_valid_d = 1'b0;
            drop_d      = cal_q;
        end else if (alu.alu_done && !drop_q) begin
            out_valid_d = 1'b1;
            out_value_d = alu.alu_result;
            out_rob_d   = dispatch_tag_q[alu.alu_index];
        end else if (rdy_in) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q    <= '0;
            qj_busy_q <= '0;
            qk_busy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]           <= '0;
                vj_q[i]           <= '0;
                vk_q[i]           <= '0;
                qj_q[i]           <= '0;
                qk_q[i]           <= '0;
                dest_q[i]         <= '0;
                dispatch_tag_q[i] <= '0;
`ifdef RS_AGE_SELECT_EN
                age_q[i]          <= '0;
`endif
            end
            cal_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            alu_op_q    <= '0;
            index_q     <= '0;
            out_valid_q <= 1'b0;
            out_rob_q   <= '0;
            out_value_q <= '0;
            drop_q      <= 1'b0;
        end else begin
            busy_q         <= busy_d;
            qj_busy_q      <= qj_busy_d;
            qk_busy_q      <= qk_busy_d;
            op_q           <= op_d;
            vj_q           <= vj_d;
            vk_q           <= vk_d;
            qj_q           <= qj_d;
            qk_q           <= qk_d;
            dest_q         <= dest_d;
            dispatch_tag_q <= dispatch_tag_d;
`ifdef RS_AGE_SELECT_EN
            age_q          <= age_d;
`endif
            cal_q          <= cal_d;
            a_q            <= a_d;
            b_q            <= b_d;
            alu_op_q       <= alu_op_d;
            index_q        <= index_d;
            out_valid_q    <= out_valid_d;
            out_rob_q      <= out_rob_d;
            out_value_q    <= out_value_d;
            drop_q         <= drop_d;
        end
    end

    assign alu.cal          = cal_q & rdy_in;
    assign alu.a            = a_q;
    assign alu.b            = b_q;
    assign alu.alu_op       = alu_op_q;
    assign alu.to_alu_index = index_q;
    assign out_valid        = out_valid_q;
    assign out_rob          = out_rob_q;
    assign out_value        = out_value_q;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: expected dispatches and results are queued at issue
// time and retired by a negedge monitor; a small registered ALU stub closes the handshake.
module tb_alu_reservation_station;
    localparam int ROB_WIDTH = 4;
    localparam int RS_WIDTH  = 2;
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;

    typedef struct {
        logic [31:0]         a;
        logic [31:0]         b;
        logic [3:0]          op;
        logic [RS_WIDTH-1:0] idx;
    } disp_t;

    typedef struct {
        logic [ROB_WIDTH-1:0] rob;
        logic [31:0]          value;
    } res_t;

    logic                 clk_in = 1'b0;
    logic                 rst_in;
    logic                 rdy_in;
    logic                 clear;
    logic                 issue_valid;
    logic [3:0]           issue_op;
    logic [31:0]          issue_vj;
    logic [31:0]          issue_vk;
    logic [ROB_WIDTH-1:0] issue_qj;
    logic [ROB_WIDTH-1:0] issue_qk;
    logic                 issue_qj_busy;
    logic                 issue_qk_busy;
    logic [ROB_WIDTH-1:0] issue_dest;
    logic                 rs_full;
    logic                 cdb_valid;
    logic [ROB_WIDTH-1:0] cdb_rob;
    logic [31:0]          cdb_value;
    logic                 out_valid;
    logic [ROB_WIDTH-1:0] out_rob;
    logic [31:0]          out_value;

    alu_reservation_station_if #(.RS_WIDTH(RS_WIDTH)) alu_bus ();

    alu_reservation_station #(.ROB_WIDTH(ROB_WIDTH), .RS_WIDTH(RS_WIDTH)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .clear         (clear),
        .issue_valid   (issue_valid),
        .issue_op      (issue_op),
        .issue_vj      (issue_vj),
        .issue_vk      (issue_vk),
        .issue_qj      (issue_qj),
        .issue_qk      (issue_qk),
        .issue_qj_busy (issue_qj_busy),
        .issue_qk_busy (issue_qk_busy),
        .issue_dest    (issue_dest),
        .rs_full       (rs_full),
        .cdb_valid     (cdb_valid),
        .cdb_rob       (cdb_rob),
        .cdb_value     (cdb_value),
        .alu           (alu_bus),
        .out_valid     (out_valid),
        .out_rob       (out_rob),
        .out_value     (out_value)
    );

    always #5 clk_in = ~clk_in;

    // Single-cycle ALU stub: computes on every edge where cal is high.
    always @(posedge clk_in) begin
        alu_bus.alu_done   <= alu_bus.cal;
        alu_bus.alu_index  <= alu_bus.to_alu_index;
        alu_bus.alu_result <= (alu_bus.alu_op == OP_SUB) ? (alu_bus.a - alu_bus.b) : (alu_bus.a + alu_bus.b);
    end

    disp_t disp_q[$];
    res_t  res_q[$];
    disp_t exp_disp;
    res_t  exp_res;
    int    total = 0;
    int    bad = 0;
    int    cal_count = 0;
    int    out_count = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic void expectDispatch(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op, input logic [RS_WIDTH-1:0] idx);
        disp_q.push_back('{a: a, b: b, op: op, idx: idx});
    endfunction

    function automatic void expectResult(input logic [ROB_WIDTH-1:0] rob, input logic [31:0] value);
        res_q.push_back('{rob: rob, value: value});
    endfunction

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                 input logic [ROB_WIDTH-1:0] qj, input logic qj_busy,
                                 input logic [ROB_WIDTH-1:0] qk, input logic qk_busy,
                                 input logic [ROB_WIDTH-1:0] dest);
        issue_valid   = 1'b1;
        issue_op      = op;
        issue_vj      = vj;
        issue_vk      = vk;
        issue_qj      = qj;
        issue_qj_busy = qj_busy;
        issue_qk      = qk;
        issue_qk_busy = qk_busy;
        issue_dest    = dest;
        tick();
        issue_valid   = 1'b0;
    endtask

    // Retire scoreboard entries as the DUT produces ALU requests and results.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (alu_bus.cal) begin
                cal_count++;
                checkOutput("dispatch expected", 32'(disp_q.size() != 0), 32'd1);
                if (disp_q.size() != 0) begin
                    exp_disp = disp_q.pop_front();
                    checkOutput("dispatch a", alu_bus.a, exp_disp.a);
                    checkOutput("dispatch b", alu_bus.b, exp_disp.b);
                    checkOutput("dispatch op", 32'(alu_bus.alu_op), 32'(exp_disp.op));
                    checkOutput("dispatch index", 32'(alu_bus.to_alu_index), 32'(exp_disp.idx));
                end
            end
            if (out_valid && rdy_in) begin
                out_count++;
                checkOutput("result expected", 32'(res_q.size() != 0), 32'd1);
                if (res_q.size() != 0) begin
                    exp_res = res_q.pop_front();
                    checkOutput("result rob", 32'(out_rob), 32'(exp_res.rob));
                    checkOutput("result value", out_value, exp_res.value);
                end
            end
        end
    end

    initial begin
        int cal_base;
        int out_base;

        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        clear         = 1'b0;
        issue_valid   = 1'b0;
        issue_op      = '0;
        issue_vj      = '0;
        issue_vk      = '0;
        issue_qj      = '0;
        issue_qk      = '0;
        issue_qj_busy = 1'b0;
        issue_qk_busy = 1'b0;
        issue_dest    = '0;
        cdb_valid     = 1'b0;
        cdb_rob       = '0;
        cdb_value     = '0;

        @(negedge clk_in);
        checkOutput("reset cal", 32'(alu_bus.cal), 32'd0);
        checkOutput("reset a", alu_bus.a, 32'd0);
        checkOutput("reset b", alu_bus.b, 32'd0);
        checkOutput("reset alu_op", 32'(alu_bus.alu_op), 32'd0);
        checkOutput("reset index", 32'(alu_bus.to_alu_index), 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_rob", 32'(out_rob), 32'd0);
        checkOutput("reset out_value", out_value, 32'd0);
        checkOutput("reset rs_full", 32'(rs_full), 32'd0);
        tick();
        rst_in = 1'b0;
        tick();

        $display("[TB] basic add latency");
        expectDispatch(32'd5, 32'd7, OP_ADD, 2'd0);
        expectResult(4'd3, 32'd12);
        applyStimulus(OP_ADD, 32'd5, 32'd7, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3);
        @(negedge clk_in);
        checkOutput("add cal cycle1", 32'(alu_bus.cal), 32'd0);
        tick();
        @(negedge clk_in);
        checkOutput("add cal cycle2", 32'(alu_bus.cal), 32'd1);
        tick();
        @(negedge clk_in);
        checkOutput("add out_valid cycle3", 32'(out_valid), 32'd0);
        tick();
        @(negedge clk_in);
        checkOutput("add out_valid cycle4", 32'(out_valid), 32'd1);
        repeat (4) tick();

        $display("[TB] cdb wakeup");
        expectDispatch(32'd10, 32'd1, OP_SUB, 2'd0);
        expectResult(4'd4, 32'd9);
        applyStimulus(OP_SUB, 32'd0, 32'd1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd4);
        tick();
        tick();
        cdb_valid = 1'b1;
        cdb_rob   = 4'd2;
        cdb_value = 32'd10;
        @(negedge clk_in);
        checkOutput("wake cal cycle3", 32'(alu_bus.cal), 32'd0);
        tick();
        cdb_valid = 1'b0;
        @(negedge clk_in);
        checkOutput("wake cal cycle4", 32'(alu_bus.cal), 32'd0);
        tick();
        @(negedge clk_in);
        checkOutput("wake cal cycle5", 32'(alu_bus.cal), 32'd1);
        repeat (6) tick();

        $display("[TB] full station");
        cal_base = cal_count;
        for (int i = 0; i < 4; i++) begin
            expectDispatch(32'h100, 32'(i), OP_ADD, RS_WIDTH'(i));
            expectResult(ROB_WIDTH'(8 + i), 32'h100 + 32'(i));
            applyStimulus(OP_ADD, 32'd0, 32'(i), 4'd7, 1'b1, 4'd0, 1'b0, ROB_WIDTH'(8 + i));
        end
        @(negedge clk_in);
        checkOutput("full after 4 issues", 32'(rs_full), 32'd1);
        applyStimulus(OP_ADD, 32'd100, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd15);
        @(negedge clk_in);
        checkOutput("full after dropped issue", 32'(rs_full), 32'd1);
        cdb_valid = 1'b1;
        cdb_rob   = 4'd7;
        cdb_value = 32'h100;
        tick();
        cdb_valid = 1'b0;
        @(negedge clk_in);
        checkOutput("full before first dispatch", 32'(rs_full), 32'd1);
        tick();
        @(negedge clk_in);
        checkOutput("full after first dispatch", 32'(rs_full), 32'd0);
        repeat (8) tick();
        checkOutput("full dispatch count", 32'(cal_count - cal_base), 32'd4);

        $display("[TB] allocation bypass and self wakeup");
        expectDispatch(32'h20, 32'd3, OP_ADD, 2'd0);
        expectResult(4'd2, 32'h23);
        expectDispatch(32'd1, 32'h23, OP_ADD, 2'd1);
        expectResult(4'd13, 32'h24);
        cdb_valid = 1'b1;
        cdb_rob   = 4'd5;
        cdb_value = 32'h20;
        applyStimulus(OP_ADD, 32'd0, 32'd3, 4'd5, 1'b1, 4'd0, 1'b0, 4'd2);
        cdb_valid = 1'b0;
        applyStimulus(OP_ADD, 32'd1, 32'd0, 4'd0, 1'b0, 4'd2, 1'b1, 4'd13);
        @(negedge clk_in);
        checkOutput("bypass cal cycle2", 32'(alu_bus.cal), 32'd1);
        repeat (10) tick();

        $display("[TB] pause");
        cal_base = cal_count;
        out_base = out_count;
        expectDispatch(32'd1, 32'd2, OP_ADD, 2'd0);
        expectResult(4'd5, 32'd3);
        applyStimulus(OP_ADD, 32'd1, 32'd2, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5);
        tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            checkOutput("pause cal gated", 32'(alu_bus.cal), 32'd0);
            tick();
        end
        rdy_in = 1'b1;
        repeat (6) tick();
        checkOutput("pause dispatch count", 32'(cal_count - cal_base), 32'd1);
        checkOutput("pause result count", 32'(out_count - out_base), 32'd1);

        $display("[TB] clear");
        cal_base = cal_count;
        out_base = out_count;
        applyStimulus(OP_ADD, 32'd0, 32'd4, 4'd9, 1'b1, 4'd0, 1'b0, 4'd7);
        applyStimulus(OP_ADD, 32'd0, 32'd5, 4'd9, 1'b1, 4'd0, 1'b0, 4'd8);
        expectDispatch(32'd1, 32'd1, OP_ADD, 2'd2);
        applyStimulus(OP_ADD, 32'd1, 32'd1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6);
        tick();
        clear         = 1'b1;
        issue_valid   = 1'b1;
        issue_op      = OP_ADD;
        issue_vj      = 32'd50;
        issue_vk      = 32'd60;
        issue_qj_busy = 1'b0;
        issue_qk_busy = 1'b0;
        issue_dest    = 4'd12;
        @(negedge clk_in);
        checkOutput("clear cal in flush cycle", 32'(alu_bus.cal), 32'd1);
        tick();
        clear       = 1'b0;
        issue_valid = 1'b0;
        @(negedge clk_in);
        checkOutput("clear cal after", 32'(alu_bus.cal), 32'd0);
        checkOutput("clear out_valid after", 32'(out_valid), 32'd0);
        checkOutput("clear rs_full after", 32'(rs_full), 32'd0);
        tick();
        @(negedge clk_in);
        checkOutput("clear squashed result", 32'(out_valid), 32'd0);
        cdb_valid = 1'b1;
        cdb_rob   = 4'd9;
        cdb_value = 32'd77;
        tick();
        cdb_valid = 1'b0;
        repeat (6) tick();
        checkOutput("clear dispatch count", 32'(cal_count - cal_base), 32'd1);
        checkOutput("clear result count", 32'(out_count - out_base), 32'd0);

        $display("[TB] reset mid-operation");
        out_base = out_count;
        expectDispatch(32'd2, 32'd2, OP_ADD, 2'd0);
        applyStimulus(OP_ADD, 32'd2, 32'd2, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1);
        tick();
        @(negedge clk_in);
        #1;
        checkOutput("reset-mid cal before", 32'(alu_bus.cal), 32'd1);
        #1;
        rst_in = 1'b1;
        #1;
        checkOutput("reset-mid cal", 32'(alu_bus.cal), 32'd0);
        checkOutput("reset-mid a", alu_bus.a, 32'd0);
        checkOutput("reset-mid b", alu_bus.b, 32'd0);
        checkOutput("reset-mid out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset-mid rs_full", 32'(rs_full), 32'd0);
        #1;
        rst_in = 1'b0;
        repeat (6) tick();
        checkOutput("reset-mid result count", 32'(out_count - out_base), 32'd0);

        checkOutput("dispatch queue drained", 32'(disp_q.size()), 32'd0);
        checkOutput("result queue drained", 32'(res_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_reservation_station.md
Name: alu_reservation_station

Overview:
- Reservation station feeding the single-cycle ALU in the Tomasulo core; it is the issuing end of the ALU's cal/a/b/alu_op/index handshake and the consumer of its to_rs/to_rs_index/result return.
- Holds 2^RS_WIDTH renamed ALU/branch ops from decode, wakes operands on CDB broadcasts and on its own results, and dispatches one ready op per cycle.
- Returns results, tagged with the ROB index, to the ROB/CDB.

Parameters:
- ROB_WIDTH, 4, ROB tag width.
- RS_WIDTH, 2, entry index width; depth = 2^RS_WIDTH.

Ports:
- clk_in input 1: clock.
- rst_in input 1: reset, asynchronous, active-high.
- rdy_in input 1: global ready; low = pause.
- clear input 1: misprediction flush, effective only when rdy_in=1.
- issue_valid input 1: new op offered.
- issue_op input 4: ALU opcode, same encoding as the ALU.
- issue_vj, issue_vk input 32 each: operand values.
- issue_qj, issue_qk input ROB_WIDTH each: producer tags.
- issue_qj_busy, issue_qk_busy input 1 each: operand still pending.
- issue_dest input ROB_WIDTH: destination ROB tag.
- rs_full output 1: no free entry (combinational).
- cdb_valid input 1, cdb_rob input ROB_WIDTH, cdb_value input 32: external broadcast.
- cal output 1, a output 32, b output 32, alu_op output 4, to_alu_index output RS_WIDTH: to the ALU.
- alu_done input 1, alu_index input RS_WIDTH, alu_result input 32: from the ALU (to_rs/to_rs_index/result).
- out_valid output 1, out_rob output ROB_WIDTH, out_value output 32: result to ROB/CDB.

Behaviour:
- Reset (async): all entries not busy. a=b=0, alu_op=0, to_alu_index=0, cal=0, out_valid=0, out_rob=0, out_value=0, rs_full=0.
- Pause: rdy_in=0 holds all state except the result latch. cal output = cal_q AND rdy_in, so the ALU never computes while paused.
- Allocation: on a rising edge with issue_valid=1 and rs_full=0, the lowest-index free entry is written. Decode must not offer issue_valid while rs_full=1; if it does, the op is dropped.
- Allocation bypass: if cdb or out broadcasts the tag the incoming op waits on in the same cycle, that value is captured and the operand is marked ready at allocation.
- Wakeup: each cycle, every busy entry waiting on tag T takes the value of a valid cdb_rob==T or out_rob==T broadcast. cdb and out may carry different tags in the same cycle; both apply.
- Select/dispatch:
  - Each active cycle, pick the lowest-index busy entry with both operands ready.
  - At the edge, register cal_q=1, a=vj, b=vk, alu_op, to_alu_index=entry. The entry is freed at that edge and its dest is written to dispatch_tag[entry].
  - If no entry is ready, cal_q=0.
  - Latency: issue cycle N, entry visible N+1, cal high N+2, alu_done N+3, out_valid N+4.
- Result latch:
  - Captures on any edge with alu_done=1, regardless of rdy_in: out_value=alu_result, out_rob=dispatch_tag[alu_index].
  - out_valid stays high until one rdy_in=1 edge passes, then drops, unless a new capture occurs on that edge.
  - At most one pending result exists, since cal is gated while paused.
- dispatch_tag[i] overwrite safety: an entry freed at edge E can next dispatch no earlier than edge E+2, which is the same edge that reads its tag, so the read always returns the old value.
- Full: rs_full=1 iff all entries are busy. An entry freed by dispatch is reusable on the next edge.
- Clear (rdy_in=1): on the next edge, all entries are freed, cal_q=0, and the result latch is invalidated. A same-cycle issue is dropped.
- Reset mid-operation: reset wins and outputs return to reset values immediately.

Optional Feature:
- RS_AGE_SELECT_EN defined: select and allocation-order use an age matrix, so the oldest ready entry dispatches first; an entry freed by clear or dispatch leaves the ordering.
- Not defined: fixed lowest-index-first select; no age state.

Test Plan:
- Issue ADD vj=5 vk=7 both ready, dest=3, in cycle 0 -> cal=1 in cycle 2 with a=5, b=7, alu_op=0000, index=0; out_valid in cycle 4 with out_rob=3, out_value=12.
- Issue SUB with qj=2 busy, vk=1, then cdb rob=2 value=10 in cycle 3 -> cal in cycle 5 with a=10, b=1; out_value=9.
- Issue 4 ops waiting on tag 7 -> rs_full=1; further issue_valid is ignored; cdb tag 7 -> dispatches on consecutive cycles at indices 0,1,2,3, and rs_full=0 the cycle after the first dispatch.
- Issue with qj=5 busy in the same cycle as cdb rob=5 value=0x20 -> the entry dispatches 2 cycles later with a=0x20, with no further broadcast needed.
- Hold rdy_in=0 for 3 cycles while cal_q=1 -> cal stays 0; after resume, exactly one ALU op and one out_valid pulse.
- Assert clear with 2 busy entries and cal_q=1 -> next cycle cal=0, out_valid=0, rs_full=0, and no later result appears; repeat with rst_in pulsed mid-cycle -> outputs clear asynchronously.
